// File: rtl/aes_ctr_reg.sv
// aes_ctr_reg: sliced 128-bit AES-CTR counter register with handshake FSM.
// An external FSM increments the counter one slice at a time.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   iv_load_i, iv_i      load the counter (IDLE only)
//   incr_req_i           level request for one increment
//   incr_ack_o           one-cycle pulse when the increment is done
//   busy_o               high whenever not IDLE
//   ctr_o                current counter value
//   fsm_incr_o           increment request to the counter FSM
//   fsm_ready_i          counter FSM ready
//   fsm_alert_i          counter FSM alert
//   ctr_slice_idx_i      slice index chosen by the FSM
//   ctr_slice_o          addressed slice (combinational)
//   ctr_slice_i          incremented slice from the FSM
//   ctr_we_i             slice write enable (legal in BUSY only)
//   alert_o              sticky fatal alert, cleared only by reset
//
// Optional feature: define AES_CTR_REG_PARITY_EN for one even-parity
// bit per slice, checked on the addressed slice in HANDSHAKE and BUSY.
module aes_ctr_reg #(
  parameter int SliceSize = 16,
  parameter int NumSlices = 8,
  localparam int CtrW = SliceSize * NumSlices,
  localparam int IdxW = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 iv_load_i,
  input  logic [CtrW-1:0]      iv_i,
  input  logic                 incr_req_i,
  output logic                 incr_ack_o,
  output logic                 busy_o,
  output logic [CtrW-1:0]      ctr_o,
  output logic                 fsm_incr_o,
  input  logic                 fsm_ready_i,
  input  logic                 fsm_alert_i,
  input  logic [IdxW-1:0]      ctr_slice_idx_i,
  output logic [SliceSize-1:0] ctr_slice_o,
  input  logic [SliceSize-1:0] ctr_slice_i,
  input  logic                 ctr_we_i,
  output logic                 alert_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HANDSHAKE = 3'd1,
    BUSY      = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_d;

  logic [NumSlices-1:0][SliceSize-1:0] r_ctr;

  logic r_ack;
  logic r_incr;
  logic r_busy;
  logic r_alert;
  logic w_par_err;
  logic w_load;
  logic w_write;

  assign ctr_o       = r_ctr;
  assign ctr_slice_o = r_ctr[ctr_slice_idx_i];
  assign incr_ack_o  = r_ack;
  assign fsm_incr_o  = r_incr;
  assign busy_o      = r_busy;
  assign alert_o     = r_alert;

  assign w_load  = (r_state == IDLE) && iv_load_i;
  assign w_write = (r_state == BUSY) && ctr_we_i;

`ifdef AES_CTR_REG_PARITY_EN
  logic [NumSlices-1:0] r_par;

  assign w_par_err = ((r_state == HANDSHAKE) || (r_state == BUSY)) &&
                     ((^ctr_slice_o) != r_par[ctr_slice_idx_i]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_par <= '0;
    end else if (w_load) begin
      for (int k = 0; k < NumSlices; k++) begin
        r_par[k] <= ^iv_i[k*SliceSize +: SliceSize];
      end
    end else if (w_write) begin
      r_par[ctr_slice_idx_i] <= ^ctr_slice_i;
    end
  end
`else
  assign w_par_err = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        // A load wins; the request is picked up once the load is gone.
        if (!iv_load_i && incr_req_i) w_state_d = HANDSHAKE;
      end
      HANDSHAKE: begin
        if (fsm_ready_i) w_state_d = BUSY;
      end
      BUSY: begin
        if (fsm_ready_i) w_state_d = DONE;
      end
      DONE:    w_state_d = IDLE;
      ERROR:   w_state_d = ERROR;
      default: w_state_d = ERROR;
    endcase
    if (r_state != ERROR) begin
      if (fsm_alert_i || w_par_err ||
          (ctr_we_i && (r_state != BUSY))) begin
        w_state_d = ERROR;
      end
    end
  end

  // Outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ctr   <= '0;
      r_ack   <= 1'b0;
      r_incr  <= 1'b0;
      r_busy  <= 1'b0;
      r_alert <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ack   <= (w_state_d == DONE);
      r_incr  <= (w_state_d == HANDSHAKE);
      r_busy  <= (w_state_d != IDLE);
      r_alert <= (w_state_d == ERROR);
      if (w_load) begin
        r_ctr <= iv_i;
      end else if (w_write) begin
        r_ctr[ctr_slice_idx_i] <= ctr_slice_i;
      end
    end
  end

endmodule

// File: tb/tb_aes_ctr_reg.sv
// tb_aes_ctr_reg: directed self-checking bench for aes_ctr_reg.
// The bench plays the role of the slice-increment FSM.
module tb_aes_ctr_reg;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         iv_load_i;
  logic [127:0] iv_i;
  logic         incr_req_i;
  logic         incr_ack_o;
  logic         busy_o;
  logic [127:0] ctr_o;
  logic         fsm_incr_o;
  logic         fsm_ready_i;
  logic         fsm_alert_i;
  logic [2:0]   ctr_slice_idx_i;
  logic [15:0]  ctr_slice_o;
  logic [15:0]  ctr_slice_i;
  logic         ctr_we_i;
  logic         alert_o;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  aes_ctr_reg dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .iv_load_i       (iv_load_i),
    .iv_i            (iv_i),
    .incr_req_i      (incr_req_i),
    .incr_ack_o      (incr_ack_o),
    .busy_o          (busy_o),
    .ctr_o           (ctr_o),
    .fsm_incr_o      (fsm_incr_o),
    .fsm_ready_i     (fsm_ready_i),
    .fsm_alert_i     (fsm_alert_i),
    .ctr_slice_idx_i (ctr_slice_idx_i),
    .ctr_slice_o     (ctr_slice_o),
    .ctr_slice_i     (ctr_slice_i),
    .ctr_we_i        (ctr_we_i),
    .alert_o         (alert_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (incr_ack_o === 1'b1) ack_cnt++;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    ack_cnt = 0;
  endtask

  task automatic load(input logic [127:0] v);
    iv_i = v;
    iv_load_i = 1'b1;
    tick();
    iv_load_i = 1'b0;
  endtask

  // Full increment: handshake, n slice writes of v, ready, ack.
  task automatic do_incr(input int n, input logic [15:0] v);
    incr_req_i = 1'b1;
    tick();
    fsm_ready_i = 1'b1;
    tick();
    fsm_ready_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      ctr_slice_idx_i = 3'(k);
      ctr_slice_i = v;
      ctr_we_i = 1'b1;
      tick();
    end
    ctr_we_i = 1'b0;
    fsm_ready_i = 1'b1;
    tick();
    fsm_ready_i = 1'b0;
    incr_req_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    iv_load_i = 1'b0;
    iv_i = '0;
    incr_req_i = 1'b0;
    fsm_ready_i = 1'b0;
    fsm_alert_i = 1'b0;
    ctr_slice_idx_i = '0;
    ctr_slice_i = '0;
    ctr_we_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    checks++;
    if (ctr_o !== '0) begin
      errors++;
      $display("FAIL reset_ctr: got %h want 0", ctr_o);
    end
    checks++;
    if ({busy_o, alert_o, incr_ack_o, fsm_incr_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {busy_o, alert_o, incr_ack_o, fsm_incr_o});
    end
  endtask

  task automatic test_incr_low();
    logic [127:0] exp;
    do_reset();
    load(128'h00FF);
    checks++;
    if (ctr_o !== 128'h00FF) begin
      errors++;
      $display("FAIL load_ctr: got %h want 00ff", ctr_o);
    end
    ctr_slice_idx_i = 3'd0;
    #1;
    checks++;
    if (ctr_slice_o !== 16'h00FF) begin
      errors++;
      $display("FAIL slice_rd0: got %h want 00ff", ctr_slice_o);
    end
    incr_req_i = 1'b1;
    tick();
    checks++;
    if ({fsm_incr_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL hs_out: got %b want 11", {fsm_incr_o, busy_o});
    end
    fsm_ready_i = 1'b1;
    tick();
    fsm_ready_i = 1'b0;
    checks++;
    if ({fsm_incr_o, busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL busy_out: got %b want 01", {fsm_incr_o, busy_o});
    end
    ctr_slice_i = 16'h0100;
    ctr_we_i = 1'b1;
    tick();
    ctr_we_i = 1'b0;
    fsm_ready_i = 1'b1;
    tick();
    fsm_ready_i = 1'b0;
    incr_req_i = 1'b0;
    checks++;
    if (incr_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL ack_done: got %b want 1", incr_ack_o);
    end
    tick();
    tick();
    tick();
    exp = 128'h0100;
    checks++;
    if (ctr_o !== exp) begin
      errors++;
      $display("FAIL incr_ctr: got %h want %h", ctr_o, exp);
    end
    checks++;
    if (ack_cnt !== 1) begin
      errors++;
      $display("FAIL ack_once: got %0d want 1", ack_cnt);
    end
    checks++;
    if ({busy_o, alert_o} !== 2'b00) begin
      errors++;
      $display("FAIL back_idle: got %b want 00", {busy_o, alert_o});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    load({128{1'b1}});
    ctr_slice_idx_i = 3'd7;
    #1;
    checks++;
    if (ctr_slice_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL slice_rd7: got %h want ffff", ctr_slice_o);
    end
    do_incr(8, 16'h0000);
    checks++;
    if (ctr_o !== '0) begin
      errors++;
      $display("FAIL wrap_ctr: got %h want 0", ctr_o);
    end
    checks++;
    if ({alert_o, ack_cnt[1:0]} !== 3'b001) begin
      errors++;
      $display("FAIL wrap_flags: got alert=%b acks=%0d want 0/1",
               alert_o, ack_cnt);
    end
  endtask

  task automatic test_slices();
    do_reset();
    load(128'h8888_7777_6666_5555_4444_3333_2222_1111);
    ctr_slice_idx_i = 3'd5;
    #1;
    checks++;
    if (ctr_slice_o !== 16'h6666) begin
      errors++;
      $display("FAIL slice_rd5: got %h want 6666", ctr_slice_o);
    end
    incr_req_i = 1'b1;
    tick();
    fsm_ready_i = 1'b1;
    tick();
    fsm_ready_i = 1'b0;
    ctr_slice_idx_i = 3'd5;
    ctr_slice_i = 16'hABCD;
    ctr_we_i = 1'b1;
    tick();
    ctr_slice_idx_i = 3'd2;
    ctr_slice_i = 16'h1234;
    tick();
    ctr_we_i = 1'b0;
    fsm_ready_i = 1'b1;
    tick();
    fsm_ready_i = 1'b0;
    incr_req_i = 1'b0;
    tick();
    checks++;
    if (ctr_o !== 128'h8888_7777_ABCD_5555_4444_1234_2222_1111) begin
      errors++;
      $display("FAIL slice_wr: got %h", ctr_o);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    iv_i = 128'hDEAD_BEEF;
    iv_load_i = 1'b1;
    incr_req_i = 1'b1;
    tick();
    iv_load_i = 1'b0;
    checks++;
    if ({ctr_o, fsm_incr_o} !== {128'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL prio_load: got %h/%b want deadbeef/0",
               ctr_o, fsm_incr_o);
    end
    tick();
    checks++;
    if (fsm_incr_o !== 1'b1) begin
      errors++;
      $display("FAIL prio_incr: got %b want 1", fsm_incr_o);
    end
    iv_i = 128'h1;
    iv_load_i = 1'b1;
    tick();
    iv_load_i = 1'b0;
    checks++;
    if (ctr_o !== 128'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_ign: got %h want deadbeef", ctr_o);
    end
    incr_req_i = 1'b0;
  endtask

  task automatic test_we_idle();
    do_reset();
    load(128'h5A5A);
    ctr_slice_idx_i = 3'd0;
    ctr_slice_i = 16'hFFFF;
    ctr_we_i = 1'b1;
    tick();
    ctr_we_i = 1'b0;
    checks++;
    if ({ctr_o, alert_o, busy_o} !== {128'h5A5A, 2'b11}) begin
      errors++;
      $display("FAIL we_idle: got %h/%b%b want 5a5a/11",
               ctr_o, alert_o, busy_o);
    end
    ctr_we_i = 1'b1;
    iv_load_i = 1'b1;
    incr_req_i = 1'b1;
    fsm_ready_i = 1'b1;
    tick();
    tick();
    ctr_we_i = 1'b0;
    iv_load_i = 1'b0;
    incr_req_i = 1'b0;
    fsm_ready_i = 1'b0;
    checks++;
    if ({ctr_o, alert_o, fsm_incr_o, ack_cnt[0]} !==
        {128'h5A5A, 3'b100}) begin
      errors++;
      $display("FAIL err_sticky: got %h/%b%b%0d",
               ctr_o, alert_o, fsm_incr_o, ack_cnt);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if ({alert_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL err_clear: got %b want 00", {alert_o, busy_o});
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    load(128'h1234);
    incr_req_i = 1'b1;
    tick();
    fsm_ready_i = 1'b1;
    tick();
    fsm_ready_i = 1'b0;
    ctr_slice_idx_i = 3'd0;
    ctr_slice_i = 16'h1235;
    ctr_we_i = 1'b1;
    tick();
    ctr_we_i = 1'b0;
    incr_req_i = 1'b0;
    rst_i = 1'b1;
    fsm_ready_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if ({ctr_o, busy_o, fsm_incr_o} !== {128'h0, 2'b00}) begin
      errors++;
      $display("FAIL rst_busy: got %h/%b%b want 0/00",
               ctr_o, busy_o, fsm_incr_o);
    end
    tick();
    tick();
    fsm_ready_i = 1'b0;
    checks++;
    if ({ack_cnt[0], busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL rst_noack: got acks=%0d busy=%b want 0/0",
               ack_cnt, busy_o);
    end
  endtask

  task automatic test_fsm_alert();
    do_reset();
    load(128'h42);
    incr_req_i = 1'b1;
    tick();
    fsm_alert_i = 1'b1;
    tick();
    fsm_alert_i = 1'b0;
    checks++;
    if ({alert_o, fsm_incr_o, busy_o} !== 3'b101) begin
      errors++;
      $display("FAIL fsm_alert: got %b want 101",
               {alert_o, fsm_incr_o, busy_o});
    end
    incr_req_i = 1'b0;
  endtask

`ifdef AES_CTR_REG_PARITY_EN
  task automatic test_parity();
    do_reset();
    load(128'h0);
    force dut.r_par[3] = 1'b1;
    ctr_slice_idx_i = 3'd3;
    incr_req_i = 1'b1;
    tick();
    tick();
    incr_req_i = 1'b0;
    checks++;
    if (alert_o !== 1'b1) begin
      errors++;
      $display("FAIL parity: got %b want 1", alert_o);
    end
    release dut.r_par[3];
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_incr_low();
    test_wrap();
    test_slices();
    test_load_priority();
    test_we_idle();
    test_reset_busy();
    test_fsm_alert();
`ifdef AES_CTR_REG_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_ctr_reg.md
AES_CTR_REG -- requirements
Module: aes_ctr_reg

Interface
REQ-001 SHALL have parameter SliceSize, default 16, meaning bits per counter slice.
REQ-002 SHALL have parameter NumSlices, default 8, meaning number of slices; counter width is SliceSize*NumSlices (128).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port iv_load_i, input, 1, load-counter strobe.
REQ-006 SHALL have port iv_i, input, 128, counter value to load.
REQ-007 SHALL have port incr_req_i, input, 1, request one counter increment (level, held until incr_ack_o).
REQ-008 SHALL have port incr_ack_o, output, 1, one-cycle pulse when the increment has completed.
REQ-009 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port ctr_o, output, 128, current counter value.
REQ-011 SHALL have port fsm_incr_o, output, 1, drives the counter FSM increment request.
REQ-012 SHALL have port fsm_ready_i, input, 1, counter FSM ready.
REQ-013 SHALL have port fsm_alert_i, input, 1, counter FSM alert.
REQ-014 SHALL have port ctr_slice_idx_i, input, 3, slice index selected by the FSM.
REQ-015 SHALL have port ctr_slice_o, output, 16, selected slice to the FSM.
REQ-016 SHALL have port ctr_slice_i, input, 16, incremented slice from the FSM.
REQ-017 SHALL have port ctr_we_i, input, 1, slice write enable from the FSM.
REQ-018 SHALL have port alert_o, output, 1, sticky fatal alert.

Function
REQ-019 SHALL store the counter as NumSlices registers; slice k is ctr_o[16k+15:16k], and slice 0 is least significant.
REQ-020 ctr_slice_o SHALL be combinational: the slice addressed by ctr_slice_idx_i, with zero added latency.
REQ-021 SHALL implement the states IDLE, HANDSHAKE, BUSY, DONE, and ERROR.
REQ-022 IDLE: iv_load_i SHALL load iv_i into the counter on the next edge; iv_load_i SHALL take priority over incr_req_i in the same cycle, and the request stays pending.
REQ-023 IDLE with incr_req_i=1 and no load SHALL go to HANDSHAKE.
REQ-024 HANDSHAKE: fsm_incr_o=1; when fsm_ready_i=1, the block SHALL go to BUSY on the next edge.
REQ-025 BUSY: fsm_incr_o=0; each cycle with ctr_we_i=1 SHALL write ctr_slice_i into slice ctr_slice_idx_i.
REQ-026 BUSY: fsm_ready_i=1 SHALL go to DONE.
REQ-027 DONE: incr_ack_o=1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-028 iv_load_i outside IDLE SHALL be ignored; the counter is unchanged.
REQ-029 ctr_we_i outside BUSY SHALL not modify the counter and SHALL enter ERROR.
REQ-030 fsm_alert_i=1 in any state SHALL enter ERROR on the next edge.
REQ-031 ERROR SHALL be terminal until rst_i; in ERROR, alert_o=1, fsm_incr_o=0, incr_ack_o=0, busy_o=1, and writes are ignored.
REQ-032 Counter wrap-around (all-ones to zero) is produced by the FSM; the block SHALL store the written slices verbatim with no special handling.

Reset
REQ-033 rst_i=1 at a clock edge SHALL force IDLE, counter to 0, alert_o=0, incr_ack_o=0, fsm_incr_o=0, and busy_o=0, in any state, including mid-increment.
REQ-034 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-035 With macro AES_CTR_REG_PARITY_EN defined, the block SHALL store one even-parity bit per slice, updated on every load or write.
REQ-036 With the macro defined, the block SHALL check the parity of the selected slice in HANDSHAKE and BUSY; a mismatch SHALL enter ERROR.
REQ-037 Without the macro, the block SHALL have no parity storage and no parity check; behaviour is otherwise identical.

Verification
REQ-038 Load iv_i=128'h0...0_00FF, then request an increment; the FSM model writes slice 0 = 16'h0100 -> ctr_o=...0100, and incr_ack_o pulses once.
REQ-039 Load all-ones, then increment; the model writes slices 0..7 = 16'h0000 -> ctr_o=0, and alert_o=0.
REQ-040 Drive iv_load_i and incr_req_i together in IDLE -> the load happens first; fsm_incr_o rises one cycle later.
REQ-041 Pulse ctr_we_i in IDLE -> counter unchanged, and alert_o=1 until rst_i.
REQ-042 Assert rst_i during BUSY after slice 0 is written -> ctr_o=0, the state is IDLE, and no incr_ack_o pulse occurs.
REQ-043 With AES_CTR_REG_PARITY_EN defined, force a bit flip in slice 3 and then increment through slice 3 -> ERROR and alert_o=1.
